// File: rtl/dm_abscmd_seq_pkg.sv
// Shared debug-module constants: DMI register map, ABSTRACTCS/COMMAND fields,
// command types, cmderr codes and the latched request payload.
package dm_abscmd_seq_pkg;

  localparam int unsigned DMI_AW   = 7;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REGNO_W  = 16;
  localparam int unsigned SIZE_W   = 2;
  localparam int unsigned CMDERR_W = 3;

  localparam logic [DMI_AW-1:0] DMI_ADDR_DATA0      = 7'h04;
  localparam logic [DMI_AW-1:0] DMI_ADDR_DATA1      = 7'h05;
  localparam logic [DMI_AW-1:0] DMI_ADDR_DMCONTROL  = 7'h10;
  localparam logic [DMI_AW-1:0] DMI_ADDR_ABSTRACTCS = 7'h16;
  localparam logic [DMI_AW-1:0] DMI_ADDR_COMMAND    = 7'h17;

  localparam int unsigned ACS_BUSY_BIT  = 12;
  localparam int unsigned ACS_CMDERR_HI = 10;
  localparam int unsigned ACS_CMDERR_LO = 8;

  localparam int unsigned CMD_TYPE_HI      = 31;
  localparam int unsigned CMD_TYPE_LO      = 24;
  localparam int unsigned CMD_SIZE_HI      = 21;
  localparam int unsigned CMD_SIZE_LO      = 20;
  localparam int unsigned CMD_TRANSFER_BIT = 17;
  localparam int unsigned CMD_WRITE_BIT    = 16;
  localparam int unsigned CMD_REGNO_HI     = 15;
  localparam int unsigned CMD_REGNO_LO     = 0;

  localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'h0;
  localparam logic [7:0] CMDTYPE_ACCESS_MEM = 8'h2;

  localparam logic [CMDERR_W-1:0] CMDERR_NONE          = 3'd0;
  localparam logic [CMDERR_W-1:0] CMDERR_BUSY          = 3'd1;
  localparam logic [CMDERR_W-1:0] CMDERR_NOT_SUPPORTED = 3'd2;
  localparam logic [CMDERR_W-1:0] CMDERR_EXCEPTION     = 3'd3;
  localparam logic [CMDERR_W-1:0] CMDERR_HALT_RESUME   = 3'd4;
  localparam logic [CMDERR_W-1:0] CMDERR_BUS           = 3'd5;
  localparam logic [CMDERR_W-1:0] CMDERR_OTHER         = 3'd7;

  localparam logic [DATA_W-1:0] DMCONTROL_DMACTIVE = 32'h0000_0001;
  localparam logic [DATA_W-1:0] ACS_CMDERR_W1C     = 32'h0000_0700;

  typedef struct packed {
    logic               kind;
    logic               write;
    logic [REGNO_W-1:0] regno;
    logic [DATA_W-1:0]  addr;
    logic [SIZE_W-1:0]  size;
    logic [DATA_W-1:0]  wdata;
  } abs_req_t;

endpackage

// File: rtl/dm_abscmd_seq_if.sv
// Host request/response channel and DMI master channel of the abstract command sequencer.
interface dm_abscmd_seq_req_if;
  import dm_abscmd_seq_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_kind;
  logic                req_write;
  logic [REGNO_W-1:0]  req_regno;
  logic [DATA_W-1:0]   req_addr;
  logic [SIZE_W-1:0]   req_size;
  logic [DATA_W-1:0]   req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [CMDERR_W-1:0] rsp_cmderr;
  logic                rsp_timeout;

  modport master (
    output req_valid, req_kind, req_write, req_regno, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_cmderr, rsp_timeout
  );
  modport slave (
    input  req_valid, req_kind, req_write, req_regno, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_cmderr, rsp_timeout
  );
endinterface

interface dm_abscmd_seq_dmi_if;
  import dm_abscmd_seq_pkg::*;

  logic              dmi_valid;
  logic              dmi_ready;
  logic              dmi_write;
  logic [DMI_AW-1:0] dmi_addr;
  logic [DATA_W-1:0] dmi_wdata;
  logic [DATA_W-1:0] dmi_rdata;

  modport master (
    output dmi_valid, dmi_write, dmi_addr, dmi_wdata,
    input  dmi_ready, dmi_rdata
  );
  modport slave (
    input  dmi_valid, dmi_write, dmi_addr, dmi_wdata,
    output dmi_ready, dmi_rdata
  );
endinterface

// File: rtl/dm_abscmd_seq_cmd_build.sv
// Builds the abstract COMMAND word for an access-register or access-memory request.
module dm_cmd_build
  import dm_abscmd_seq_pkg::*;
(
  input  logic               kind_i,
  input  logic               write_i,
  input  logic [SIZE_W-1:0]  size_i,
  input  logic [REGNO_W-1:0] regno_i,
  output logic [DATA_W-1:0]  cmd_c_o
);

  always_comb begin
    cmd_c_o = '0;
    cmd_c_o[CMD_SIZE_HI:CMD_SIZE_LO] = size_i;
    cmd_c_o[CMD_WRITE_BIT]           = write_i;
    if (kind_i) begin
      // postincrement stays off: one access per command
      cmd_c_o[CMD_TYPE_HI:CMD_TYPE_LO] = CMDTYPE_ACCESS_MEM;
    end else begin
      cmd_c_o[CMD_TYPE_HI:CMD_TYPE_LO]   = CMDTYPE_ACCESS_REG;
      cmd_c_o[CMD_TRANSFER_BIT]          = 1'b1;
      cmd_c_o[CMD_REGNO_HI:CMD_REGNO_LO] = regno_i;
    end
  end

endmodule

// File: rtl/dm_abscmd_seq.sv
// Serialises single register/memory access requests into the DMI write/poll/read
// sequence of one abstract command; exactly one command is in flight at a time.
module dm_abscmd_seq
  import dm_abscmd_seq_pkg::*;
#(
  parameter int unsigned POLL_LIMIT  = 256,
  parameter bit          INIT_ACTIVE = 1'b1
) (
  input  logic                       clk,
  input  logic                       resetn,
  dm_abscmd_seq_req_if.slave         host,
  dm_abscmd_seq_dmi_if.master        dmi
);

  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WR_DATA1, S_WR_DATA0, S_WR_CMD,
    S_RD_ACS, S_CLR_ERR, S_RD_DATA0, S_RESP
  } state_e;

  localparam state_e RST_STATE = INIT_ACTIVE ? S_INIT : S_IDLE;

  state_e              state_q, state_d;
  abs_req_t            req_q, req_d;
  logic [CNT_W-1:0]    poll_cnt_q, poll_cnt_d;
  logic [CMDERR_W-1:0] err_q, err_d;
  logic                dmi_valid_q, dmi_valid_d;
  logic                dmi_write_q, dmi_write_d;
  logic [DMI_AW-1:0]   dmi_addr_q, dmi_addr_d;
  logic [DATA_W-1:0]   dmi_wdata_q, dmi_wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CMDERR_W-1:0] rsp_cmderr_q, rsp_cmderr_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic                txn_en, txn_write;
  logic [DMI_AW-1:0]   txn_addr;
  logic [DATA_W-1:0]   txn_wdata;
  logic [DATA_W-1:0]   cmd_word_c;
  logic                xfer_done_c;
  logic                acs_busy_c;
  logic [CMDERR_W-1:0] acs_err_c;

  dm_cmd_build u_cmd_build (
    .kind_i  (req_q.kind),
    .write_i (req_q.write),
    .size_i  (req_q.size),
    .regno_i (req_q.regno),
    .cmd_c_o (cmd_word_c)
  );

  assign xfer_done_c = dmi_valid_q && dmi.dmi_ready;
  assign acs_busy_c  = dmi.dmi_rdata[ACS_BUSY_BIT];
  assign acs_err_c   = dmi.dmi_rdata[ACS_CMDERR_HI:ACS_CMDERR_LO];

  // Next-state, DMI issue and response logic
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    poll_cnt_d    = poll_cnt_q;
    err_d         = err_q;
    dmi_valid_d   = dmi_valid_q;
    dmi_write_d   = dmi_write_q;
    dmi_addr_d    = dmi_addr_q;
    dmi_wdata_d   = dmi_wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_cmderr_d  = rsp_cmderr_q;
    rsp_timeout_d = rsp_timeout_q;
    txn_en        = 1'b0;
    txn_write     = 1'b0;
    txn_addr      = '0;
    txn_wdata     = '0;

    unique case (state_q)
      S_INIT: begin
        txn_en    = 1'b1;
        txn_write = 1'b1;
        txn_addr  = DMI_ADDR_DMCONTROL;
        txn_wdata = DMCONTROL_DMACTIVE;
        if (xfer_done_c) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (host.req_valid && req_ready_q) begin
          req_d.kind  = host.req_kind;
          req_d.write = host.req_write;
          req_d.regno = host.req_regno;
          req_d.addr  = host.req_addr;
          req_d.size  = host.req_size;
          req_d.wdata = host.req_wdata;
          if (host.req_kind)       state_d = S_WR_DATA1;
          else if (host.req_write) state_d = S_WR_DATA0;
          else                     state_d = S_WR_CMD;
        end
      end
      S_WR_DATA1: begin
        txn_en    = 1'b1;
        txn_write = 1'b1;
        txn_addr  = DMI_ADDR_DATA1;
        txn_wdata = req_q.addr;
        if (xfer_done_c) state_d = req_q.write ? S_WR_DATA0 : S_WR_CMD;
      end
      S_WR_DATA0: begin
        txn_en    = 1'b1;
        txn_write = 1'b1;
        txn_addr  = DMI_ADDR_DATA0;
        txn_wdata = req_q.wdata;
        if (xfer_done_c) state_d = S_WR_CMD;
      end
      S_WR_CMD: begin
        txn_en    = 1'b1;
        txn_write = 1'b1;
        txn_addr  = DMI_ADDR_COMMAND;
        txn_wdata = cmd_word_c;
        if (xfer_done_c) begin
          poll_cnt_d = '0;
          state_d    = S_RD_ACS;
        end
      end
      S_RD_ACS: begin
        txn_en   = 1'b1;
        txn_addr = DMI_ADDR_ABSTRACTCS;
        if (xfer_done_c) begin
          if (acs_busy_c) begin
            // counter only advances below the limit, so it can never wrap
            if ((32'(poll_cnt_q) + 32'd1) < POLL_LIMIT) begin
              poll_cnt_d = poll_cnt_q + CNT_W'(1);
            end else begin
              rsp_timeout_d = 1'b1;
              rsp_valid_d   = 1'b1;
              state_d       = S_RESP;
            end
          end else if (acs_err_c != CMDERR_NONE) begin
            err_d   = acs_err_c;
            state_d = S_CLR_ERR;
          end else if (req_q.write) begin
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            state_d = S_RD_DATA0;
          end
        end
      end
      S_CLR_ERR: begin
        txn_en    = 1'b1;
        txn_write = 1'b1;
        txn_addr  = DMI_ADDR_ABSTRACTCS;
        txn_wdata = ACS_CMDERR_W1C;
        if (xfer_done_c) begin
          rsp_cmderr_d = err_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RD_DATA0: begin
        txn_en   = 1'b1;
        txn_addr = DMI_ADDR_DATA0;
        if (xfer_done_c) begin
          rsp_rdata_d = dmi.dmi_rdata;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_cmderr_d  = '0;
          rsp_timeout_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Issue after a one-cycle gap; fields hold until the handshake retires it
    if (txn_en && !dmi_valid_q) begin
      dmi_valid_d = 1'b1;
      dmi_write_d = txn_write;
      dmi_addr_d  = txn_addr;
      dmi_wdata_d = txn_wdata;
    end else if (xfer_done_c) begin
      dmi_valid_d = 1'b0;
    end

    req_ready_d = (state_d == S_IDLE) && !rsp_valid_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= RST_STATE;
      req_q         <= '0;
      poll_cnt_q    <= '0;
      err_q         <= '0;
      dmi_valid_q   <= 1'b0;
      dmi_write_q   <= 1'b0;
      dmi_addr_q    <= '0;
      dmi_wdata_q   <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_cmderr_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      poll_cnt_q    <= poll_cnt_d;
      err_q         <= err_d;
      dmi_valid_q   <= dmi_valid_d;
      dmi_write_q   <= dmi_write_d;
      dmi_addr_q    <= dmi_addr_d;
      dmi_wdata_q   <= dmi_wdata_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_cmderr_q  <= rsp_cmderr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign host.req_ready   = req_ready_q;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_rdata   = rsp_rdata_q;
  assign host.rsp_cmderr  = rsp_cmderr_q;
  assign host.rsp_timeout = rsp_timeout_q;
  assign dmi.dmi_valid    = dmi_valid_q;
  assign dmi.dmi_write    = dmi_write_q;
  assign dmi.dmi_addr     = dmi_addr_q;
  assign dmi.dmi_wdata    = dmi_wdata_q;

endmodule

// File: doc/dm_abscmd_seq.md
Name: dm_abscmd_seq

Overview:
- Host-side sequencer that turns single register or memory access requests into the DMI transaction sequence the debug module needs.
- Sequence: write DATA0/DATA1, write COMMAND, poll ABSTRACTCS until not busy, clear cmderr on error, read DATA0.
- Drives the dm DMI slave port. Sits between the DTM/host request logic and dm, and serialises all abstract commands.

Parameters:
POLL_LIMIT, 256, max ABSTRACTCS reads with busy=1 before timeout (≥1)
INIT_ACTIVE, 1, when 1, write DMCONTROL=32'h1 (dmactive) once after reset before accepting requests

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_kind  in  1  0=register (cmdtype 0), 1=memory (cmdtype 2)
req_write  in  1  1=write target, 0=read
req_regno  in  16  register number (req_kind=0)
req_addr  in  32  memory address (req_kind=1)
req_size  in  2  access size log2 (0..2) -> aarsize/aamsize[21:20]
req_wdata  in  32  write data
rsp_valid  out  1  response present, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rdata  out  32  DATA0 contents (reads, no error), else 0
rsp_cmderr  out  3  cmderr seen at completion
rsp_timeout  out  1  busy poll exhausted
dmi_valid  out  1  DMI request
dmi_ready  in  1  DMI accept
dmi_write  out  1  DMI write
dmi_addr  out  7  DMI word address [8:2]
dmi_wdata  out  32  DMI write data
dmi_rdata  in  32  DMI read data, valid in handshake cycle

Behaviour:
- Reset: all outputs 0. State is INIT if INIT_ACTIVE, else IDLE. Asserting resetn low mid-sequence aborts immediately; no response is produced.
- DMI addresses: DATA0=7'h04, DATA1=7'h05, DMCONTROL=7'h10, ABSTRACTCS=7'h16, COMMAND=7'h17. ABSTRACTCS fields: busy=bit12, cmderr=[10:8].
- DMI drive (all registered):
  - A state with a transaction sets dmi_valid=1 with its addr/write/wdata one cycle after entry (gap cycle).
  - Fields stay stable while dmi_valid=1.
  - On dmi_valid&&dmi_ready: capture dmi_rdata, dmi_valid<=0, advance.
  - Each transaction therefore costs 1 gap cycle plus the cycles waiting for ready; with dm (ready lags valid by one cycle) that is 3 cycles.
- req_ready=1 only in IDLE with rsp_valid=0. On accept, latch all req_* fields.
- COMMAND word:
  - Register: {8'h0,1'b0,1'b0,size,1'b0,1'b0,1'b1(transfer),write,regno}.
  - Memory: {8'h2,1'b0,1'b0,size,1'b0(postinc),2'b0,write,16'h0}.
  - size occupies bits [21:20]; bit 22 is 0.
- States:
  - INIT: write DMCONTROL=32'h1 -> IDLE.
  - IDLE: on accept -> memory: WR_DATA1; register write: WR_DATA0; register read: WR_CMD.
  - WR_DATA1: write req_addr -> WR_DATA0 if write, else WR_CMD.
  - WR_DATA0: write req_wdata -> WR_CMD.
  - WR_CMD: write COMMAND; clear poll counter -> RD_ACS.
  - RD_ACS: read ABSTRACTCS, then:
    - busy=1 and count+1<POLL_LIMIT: count++, re-poll.
    - busy=1 and limit reached: rsp_timeout=1 -> RESP.
    - busy=0 and cmderr≠0: latch cmderr -> CLR_ERR.
    - otherwise: read -> RD_DATA0, write -> RESP.
  - CLR_ERR: write ABSTRACTCS=32'h0000_0700 -> RESP.
  - RD_DATA0: rsp_rdata<=dmi_rdata -> RESP.
  - RESP: rsp_valid=1 until rsp_ready; rsp_* then cleared to 0 -> IDLE.
- rsp_rdata=0 for writes, errors and timeouts. The timeout path does not clear cmderr.
- No posted/overlapping commands: exactly one outstanding abstract command.
- Poll counter width is clog2(POLL_LIMIT+1); it saturates and never wraps.
- A rsp_ready without rsp_valid is ignored. A request arriving while rsp_valid=1 waits.

Decomposition:
- Shared debug header: DMI_ADDR_* constants, ABSTRACTCS/COMMAND field ranges, CMDTYPE_*, CMDERR_* (extend existing).
- Sequencer state encoding stays local.
- One natural combinational sub-module, dm_cmd_build: builds the COMMAND word from kind/write/size/regno.

Test Plan:
- INIT_ACTIVE=1, reset release -> first DMI op: write addr 7'h10 data 32'h1; req_ready rises only after its handshake.
- Register read regno=16'h1008, dm model busy clears on first poll, DATA0=32'hDEAD_BEEF:
  - DMI sequence: COMMAND write 32'h0022_1008, ABSTRACTCS read, DATA0 read.
  - rsp_rdata=32'hDEAD_BEEF, cmderr=0, rsp_valid 10 cycles after accept.
- Memory write addr 32'h8000_0010, wdata 32'h1234_5678, size 2:
  - DMI sequence: DATA1←addr, DATA0←wdata, COMMAND 32'h0221_0000, ABSTRACTCS poll.
  - rsp_cmderr=0, rsp_rdata=0.
- Busy for 3 polls, then cmderr=3'd3: 4 ABSTRACTCS reads, then write ABSTRACTCS 32'h700, rsp_cmderr=3, no DATA0 read.
- POLL_LIMIT=4, busy stuck: exactly 4 polls, rsp_timeout=1, no further DMI traffic, rsp held with rsp_ready=0 for 5 cycles.
- resetn low during WR_CMD with dmi_valid=1 -> all outputs 0 asynchronously; after release, INIT repeats and a new request completes normally.
